// File: rtl/dtmf_decode_ctrl_if.sv
// Lookup handshake and digit-stream signals shared by the DTMF decode controller and its neighbours.
// master = controller side, slave = lookup/host side.
interface dtmf_decode_ctrl_if;
    logic        lut_go;
    logic        lut_rst_n;
    logic        lut_done;
    logic [15:0] lut_tone;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        digit_ready;

    modport master (
        output lut_go, lut_rst_n, digit, digit_valid,
        input  lut_done, lut_tone, digit_ready
    );

    modport slave (
        input  lut_go, lut_rst_n, digit, digit_valid,
        output lut_done, lut_tone, digit_ready
    );
endinterface

// File: rtl/dtmf_decode_ctrl.sv
// DTMF lookup sequencer: one lookup per frame, press/release debounce of the tone codes,
// and a small first-word-fall-through FIFO of registered digits.
module dtmf_decode_ctrl #(
    parameter int unsigned PRESS_FRAMES   = 3,
    parameter int unsigned RELEASE_FRAMES = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_start,
    dtmf_decode_ctrl_if.master          bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        overflow,
    output logic                        timeout_err,
    output logic                        frame_overrun
);
    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [4:0]  NO_TONE = 5'd16;

    typedef enum logic [1:0] {IDLE, REQ, REARM} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    tone_q, tone_d;
    logic [4:0]    cand_q, cand_d;
    logic [3:0]    run_q, run_d;
    logic          latched_q, latched_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [3:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          tout_q, tout_d;
    logic          overrun_q, overrun_d;
    logic          push, pop, full;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tone_d    = tone_q;
        cand_d    = cand_q;
        run_d     = run_q;
        latched_d = latched_q;
        tout_d    = tout_q;
        overrun_d = overrun_q | (frame_start && (state_q != IDLE));
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (frame_start) state_d = REQ;
            end
            REQ: begin
                // lut_done takes priority over a timeout landing in the same cycle
                if (bus.lut_done) begin
                    tone_d  = (bus.lut_tone > 16'd16) ? NO_TONE : bus.lut_tone[4:0];
                    state_d = REARM;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tone_d  = NO_TONE;
                    tout_d  = 1'b1;
                    state_d = REARM;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REARM: begin
                state_d = IDLE;
                timer_d = '0;
                cand_d  = tone_q;
                if (tone_q == cand_q) run_d = (run_q == 4'd15) ? 4'd15 : run_q + 4'd1;
                else                  run_d = 4'd1;
                if (!latched_q && (cand_d != NO_TONE) && (run_d == 4'(PRESS_FRAMES))) begin
                    push      = 1'b1;
                    latched_d = 1'b1;
                end else if (latched_q && (cand_d == NO_TONE) && (run_d >= 4'(RELEASE_FRAMES))) begin
                    latched_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push into a full FIFO still succeeds when the head is popped in the same cycle.
    always_comb begin
        pop     = (count_q != '0) && bus.digit_ready;
        full    = (count_q == CW'(FIFO_DEPTH));
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push) begin
            if (!full || pop) begin
                mem_d[wr_q] = cand_d[3:0];
                wr_d        = ptr_inc(wr_q);
                if (!pop) count_d = count_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
            if (!push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            tone_q    <= NO_TONE;
            cand_q    <= NO_TONE;
            run_q     <= '0;
            latched_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tout_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tone_q    <= tone_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            latched_q <= latched_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tout_q    <= tout_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end

    assign bus.lut_go      = (state_q == REQ);
    assign bus.lut_rst_n   = (state_q != REARM);
    assign bus.digit_valid = (count_q != '0);
    assign bus.digit       = (count_q != '0) ? mem_q[rd_q] : '0;
    assign fifo_count      = count_q;
    assign busy            = (state_q != IDLE);
    assign overflow        = ovf_q;
    assign timeout_err     = tout_q;
    assign frame_overrun   = overrun_q;
endmodule
